// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a COUNT/(HI,LO)*/CHK byte frame into 16-bit
// words, writes them to RAM from address 0 and releases the CPU core once the checksum matches.
module prog_loader #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        load_req,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [15:0] mem_data,
   output logic        cpu_rst,
   output logic        done,
   output logic [1:0]  err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  total;
   logic [7:0]  idx;
   logic [7:0]  csum;
   logic [15:0] tmo_cnt;
   logic        accept;
   logic        tmo_hit;

   assign accept  = byte_valid && byte_ready;
   assign tmo_hit = (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         byte_ready <= 1'b1;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
         err        <= 2'd0;
         total      <= '0;
         idx        <= '0;
         csum       <= '0;
         tmo_cnt    <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  total   <= byte_data;
                  csum    <= byte_data;
                  idx     <= '0;
                  tmo_cnt <= '0;
                  state   <= S_HI;
               end
            end

            // An accepted byte takes priority over the counter reaching its limit.
            S_HI: begin
               if (accept) begin
                  mem_data[15:8] <= byte_data;
                  csum           <= csum + byte_data;
                  tmo_cnt        <= '0;
                  state          <= S_LO;
               end else if (tmo_hit) begin
                  err        <= 2'd1;
                  byte_ready <= 1'b0;
                  state      <= S_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end

            S_LO: begin
               if (accept) begin
                  mem_data[7:0] <= byte_data;
                  csum          <= csum + byte_data;
                  tmo_cnt       <= '0;
                  mem_we        <= 1'b1;
                  mem_addr      <= idx;
                  byte_ready    <= 1'b0;
                  state         <= S_WRITE;
               end else if (tmo_hit) begin
                  err        <= 2'd1;
                  byte_ready <= 1'b0;
                  state      <= S_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end

            // total-1 wraps to 255 when COUNT=0, giving the 256-word image.
            S_WRITE: begin
               idx        <= idx + 8'd1;
               tmo_cnt    <= '0;
               byte_ready <= 1'b1;
               state      <= (idx == total - 8'd1) ? S_CHK : S_HI;
            end

            S_CHK: begin
               if (accept) begin
                  byte_ready <= 1'b0;
                  tmo_cnt    <= '0;
                  if (byte_data == csum) begin
                     done    <= 1'b1;
                     cpu_rst <= 1'b0;
                     state   <= S_DONE;
                  end else begin
                     err   <= 2'd2;
                     state <= S_ERR;
                  end
               end else if (tmo_hit) begin
                  err        <= 2'd1;
                  byte_ready <= 1'b0;
                  state      <= S_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end

            S_DONE, S_ERR: begin
               if (load_req) begin
                  byte_ready <= 1'b1;
                  cpu_rst    <= 1'b1;
                  done       <= 1'b0;
                  err        <= 2'd0;
                  idx        <= '0;
                  csum       <= '0;
                  tmo_cnt    <= '0;
                  state      <= S_IDLE;
               end
            end

            default: begin
               byte_ready <= 1'b1;
               cpu_rst    <= 1'b1;
               done       <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as bytes are driven
// and checked by a write monitor; status outputs are checked inline in each scenario.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_data = '0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        load_req = 1'b0;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;
   logic        cpu_rst;
   logic        done;
   logic [1:0]  err;

   int vec_cnt = 0;
   int miss_cnt = 0;
   logic [23:0] exp_q[$];

   prog_loader #(.TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .load_req   (load_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we) begin
         vec_cnt++;
         if (exp_q.size() == 0) begin
            miss_cnt++;
            $display("FAIL unexpected_write: got addr=%02h data=%04h, required no write", mem_addr, mem_data);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_data} !== e) begin
               miss_cnt++;
               $display("FAIL write: got addr=%02h data=%04h, required addr=%02h data=%04h",
                        mem_addr, mem_data, e[23:16], e[15:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      byte_data  = b;
      byte_valid = 1'b1;
      n = 0;
      while (byte_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      vec_cnt++;
      if (n >= 100) begin
         miss_cnt++;
         $display("FAIL ready_wait: got byte_ready=0 for 100 cycles, required 1");
      end
      tick();
   endtask

   task automatic idle_bus();
      byte_valid = 1'b0;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic check_status(input string name, input logic rdy, input logic crst,
                               input logic dn, input logic [1:0] e);
      vec_cnt++;
      if ({byte_ready, cpu_rst, done, err} !== {rdy, crst, dn, e}) begin
         miss_cnt++;
         $display("FAIL %s: got ready=%b cpu_rst=%b done=%b err=%0d, required ready=%b cpu_rst=%b done=%b err=%0d",
                  name, byte_ready, cpu_rst, done, err, rdy, crst, dn, e);
      end
   endtask

   task automatic check_drained(input string name);
      vec_cnt++;
      if (exp_q.size() != 0) begin
         miss_cnt++;
         $display("FAIL %s_pending: got %0d outstanding writes, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Sends one word and queues the write it should produce.
   task automatic send_word(input logic [7:0] a, input logic [15:0] w, inout logic [7:0] sum);
      send_byte(w[15:8]);
      exp_q.push_back({a, w});
      send_byte(w[7:0]);
      sum = sum + w[15:8] + w[7:0];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vec_cnt++;
      if ({mem_we, mem_addr, mem_data} !== 25'd0) begin
         miss_cnt++;
         $display("FAIL reset_port: got we=%b addr=%02h data=%04h, required 0/00/0000", mem_we, mem_addr, mem_data);
      end
      check_status("reset_status", 1'b1, 1'b1, 1'b0, 2'd0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_load();
      logic [7:0] sum;
      sum = 8'h02;
      send_byte(8'h02);
      send_word(8'h00, 16'h1234, sum);
      send_word(8'h01, 16'hABCD, sum);
      vec_cnt++;
      if (sum !== 8'hC0) begin
         miss_cnt++;
         $display("FAIL basic_sum_model: got %02h, required C0", sum);
      end
      send_byte(8'hC0);
      idle_bus();
      check_status("basic_done", 1'b0, 1'b0, 1'b1, 2'd0);
      check_drained("basic");
   endtask

   task automatic test_bad_checksum();
      logic [7:0] sum;
      pulse_load();
      check_status("bad_reload", 1'b1, 1'b1, 1'b0, 2'd0);
      sum = 8'h02;
      send_byte(8'h02);
      send_word(8'h00, 16'h1234, sum);
      send_word(8'h01, 16'hABCD, sum);
      send_byte(sum + 8'h01);
      idle_bus();
      check_status("bad_err", 1'b0, 1'b1, 1'b0, 2'd2);
      tick();
      check_status("bad_err_hold", 1'b0, 1'b1, 1'b0, 2'd2);
      pulse_load();
      check_status("bad_recover", 1'b1, 1'b1, 1'b0, 2'd0);
      check_drained("bad");
   endtask

   task automatic test_timeout();
      logic [7:0] sum;
      send_byte(8'h01);
      send_byte(8'h55);
      idle_bus();
      for (int i = 1; i <= 7; i++) begin
         tick();
         check_status($sformatf("tmo_wait%0d", i), 1'b1, 1'b1, 1'b0, 2'd0);
      end
      tick();
      check_status("tmo_expire", 1'b0, 1'b1, 1'b0, 2'd1);
      pulse_load();
      check_status("tmo_recover", 1'b1, 1'b1, 1'b0, 2'd0);
      // Same frame, LO lands on the cycle the counter reaches its limit.
      send_byte(8'h01);
      send_byte(8'h55);
      idle_bus();
      for (int i = 1; i <= 7; i++) tick();
      exp_q.push_back({8'h00, 16'h5566});
      send_byte(8'h66);
      sum = 8'h01 + 8'h55 + 8'h66;
      send_byte(sum);
      idle_bus();
      check_status("tmo_edge_done", 1'b0, 1'b0, 1'b1, 2'd0);
      check_drained("tmo");
   endtask

   task automatic test_back_to_back();
      logic [7:0]  sum;
      logic [15:0] w;
      int bp_bad;
      pulse_load();
      sum = 8'h00;
      bp_bad = 0;
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         send_word(8'(i), w, sum);
         if (byte_ready !== 1'b0) bp_bad++;
      end
      vec_cnt++;
      if (bp_bad != 0) begin
         miss_cnt++;
         $display("FAIL backpressure: got byte_ready=1 after LO %0d times, required 0", bp_bad);
      end
      send_byte(sum);
      idle_bus();
      check_status("full_done", 1'b0, 1'b0, 1'b1, 2'd0);
      tick();
      tick();
      check_drained("full");
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] sum;
      pulse_load();
      sum = 8'h03;
      send_byte(8'h03);
      send_word(8'h00, 16'h0102, sum);
      send_word(8'h01, 16'h0304, sum);
      send_byte(8'h05);
      idle_bus();
      rst = 1'b1;
      tick();
      vec_cnt++;
      if (mem_we !== 1'b0) begin
         miss_cnt++;
         $display("FAIL midrst_we: got %b, required 0", mem_we);
      end
      check_status("midrst_status", 1'b1, 1'b1, 1'b0, 2'd0);
      rst = 1'b0;
      check_drained("midrst_pre");
      sum = 8'h01;
      send_byte(8'h01);
      send_word(8'h00, 16'h7788, sum);
      send_byte(sum);
      idle_bus();
      check_status("midrst_reload", 1'b0, 1'b0, 1'b1, 2'd0);
      check_drained("midrst");
   endtask

   task automatic test_ignored_events();
      logic [7:0] sum;
      // Bytes offered in DONE are refused and change nothing.
      byte_data  = 8'hEE;
      byte_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_status($sformatf("done_offer%0d", i), 1'b0, 1'b0, 1'b1, 2'd0);
      end
      idle_bus();
      pulse_load();
      sum = 8'h01;
      send_byte(8'h01);
      send_byte(8'h9A);
      idle_bus();
      pulse_load();
      check_status("lo_loadreq", 1'b1, 1'b1, 1'b0, 2'd0);
      exp_q.push_back({8'h00, 16'h9ABC});
      send_byte(8'hBC);
      sum = sum + 8'h9A + 8'hBC;
      send_byte(sum);
      idle_bus();
      check_status("ignored_done", 1'b0, 1'b0, 1'b1, 2'd0);
      check_drained("ignored");
   endtask

   initial begin
      #1;
      test_reset();
      test_basic_load();
      test_bad_checksum();
      test_timeout();
      test_back_to_back();
      test_reset_mid_frame();
      test_ignored_events();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
